// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// The header feature is selected by UART_TX_ARB_HEADER_EN in the top module.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] UART_ARB_HDR_TAG_DEF = 4'hA;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// searching upward and wrapping modulo NUM_SRC.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // One extra bit on the sum lets the wrap work for non-power-of-two NUM_SRC.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_SRC)) begin
                sum = sum - (ID_W+1)'(NUM_SRC);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_SRC byte requesters.
// Define UART_TX_ARB_HEADER_EN to prefix each byte with a {HDR_TAG, id} header.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter int         DATA_WIDTH = 8,
    parameter logic [3:0] HDR_TAG    = UART_ARB_HDR_TAG_DEF,
    localparam int        SRC_ID_W   = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [SRC_ID_W-1:0]           cur_src
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [DATA_WIDTH-1:0] byte_r;
    logic [SRC_ID_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0]    gnt;
    logic [SRC_ID_W-1:0]   gnt_id;
    logic                  capture;
    logic                  tx_fire;
    logic [DATA_WIDTH-1:0] src_bytes [NUM_SRC];
    logic [DATA_WIDTH-1:0] hdr_byte;

    uart_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (SRC_ID_W)
    ) u_pick (
        .req    (src_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_bytes[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Tag sits in the top nibble; the source ID is right-aligned beneath it.
    assign hdr_byte = {HDR_TAG, (DATA_WIDTH-4)'(cur_src)};
    assign capture  = (state == S_IDLE) && (|(src_valid & src_ready));
    assign tx_fire  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_r  <= '0;
            cur_src <= '0;
            rr_ptr  <= '0;
        end else begin
            if (capture) begin
                byte_r  <= src_bytes[gnt_id];
                cur_src <= gnt_id;
            end
            if (state == S_DATA && tx_fire) begin
                rr_ptr <= (cur_src == SRC_ID_W'(NUM_SRC-1)) ? '0 : cur_src + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (capture) begin
`ifdef UART_TX_ARB_HEADER_EN
                    state_next = S_HDR;
`else
                    state_next = S_DATA;
`endif
                end
            end
`ifdef UART_TX_ARB_HEADER_EN
            S_HDR: begin
                if (tx_fire) state_next = S_DATA;
            end
`endif
            S_DATA: begin
                if (tx_fire) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Transmit side decodes only registered state, so tx_ready never feeds tx_valid.
    always_comb begin
        src_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: src_ready = gnt;
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = byte_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_SRC=4); header checks follow UART_TX_ARB_HEADER_EN.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [1:0]  cur_src;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_arbiter #(
        .NUM_SRC    (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .cur_src   (cur_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic t);
        rst       = r;
        src_valid = v;
        tx_ready  = t;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one whole frame from the grant cycle back to idle, tx_ready held high.
    task automatic expectFrame(input logic [1:0] id, input logic [7:0] data);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        checkOutput("grant", src_ready, oh);
        tick;
`ifdef UART_TX_ARB_HEADER_EN
        checkOutput("hdr_valid", tx_valid, 1);
        checkOutput("hdr_byte", tx_data, {4'hA, 2'b00, id});
        checkOutput("hdr_ready", src_ready, 0);
        checkOutput("hdr_src", cur_src, id);
        tick;
`endif
        checkOutput("data_valid", tx_valid, 1);
        checkOutput("data_byte", tx_data, data);
        checkOutput("data_src", cur_src, id);
        checkOutput("data_ready", src_ready, 0);
        checkOutput("data_busy", busy, 1);
        tick;
        checkOutput("idle_valid", tx_valid, 0);
        checkOutput("idle_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        src_data = {8'h44, 8'h5C, 8'h22, 8'h11};

        // Reset state, and ready following the grant while reset is held.
        applyStimulus(1, 4'b0000, 0);
        tick;
        tick;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cur_src", cur_src, 0);
        checkOutput("rst_ready_idle", src_ready, 0);
        applyStimulus(1, 4'b0010, 0);
        checkOutput("rst_ready_grant", src_ready, 4'b0010);
        applyStimulus(0, 4'b0000, 1);
        tick;

        // Single request from source 2.
        applyStimulus(0, 4'b0100, 1);
        expectFrame(2, 8'h5C);
        applyStimulus(0, 4'b0000, 1);
        checkOutput("single_no_req", src_ready, 0);

        // Pointer now 3: grant 3 from full load, then reset mid-frame.
        applyStimulus(0, 4'b1111, 1);
        checkOutput("ptr3_grant", src_ready, 4'b1000);
        tick;
        applyStimulus(1, 4'b0000, 1);
        checkOutput("midrst_pre_valid", tx_valid, 1);
`ifdef UART_TX_ARB_HEADER_EN
        checkOutput("midrst_pre_data", tx_data, 8'hA3);
`else
        checkOutput("midrst_pre_data", tx_data, 8'h44);
`endif
        tick;
        checkOutput("midrst_tx_valid", tx_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_cur_src", cur_src, 0);
        checkOutput("midrst_tx_data", tx_data, 0);
        applyStimulus(0, 4'b1111, 1);
        checkOutput("midrst_ptr0", src_ready, 4'b0001);

        // Full load held: strict order 0,1,2,3,0.
        expectFrame(0, 8'h11);
        expectFrame(1, 8'h22);
        expectFrame(2, 8'h5C);
        expectFrame(3, 8'h44);
        expectFrame(0, 8'h11);

        // Stall in S_DATA for 20 cycles on source 1.
        checkOutput("stall_grant", src_ready, 4'b0010);
        tick;
`ifdef UART_TX_ARB_HEADER_EN
        checkOutput("stall_hdr", tx_data, 8'hA1);
        tick;
`endif
        applyStimulus(0, 4'b1111, 0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("stall_valid", tx_valid, 1);
            checkOutput("stall_data", tx_data, 8'h22);
            checkOutput("stall_ready", src_ready, 0);
            tick;
        end
        applyStimulus(0, 4'b1111, 1);
        checkOutput("stall_release_data", tx_data, 8'h22);
        tick;
        checkOutput("stall_one_hs", tx_valid, 0);
        checkOutput("stall_next_grant", src_ready, 4'b0100);

        // Requester drops valid before capture; nothing is taken, pointer holds at 2.
        applyStimulus(0, 4'b0000, 1);
        checkOutput("drop_ready", src_ready, 0);
        tick;
        tick;
        checkOutput("drop_busy", busy, 0);
        checkOutput("drop_tx_valid", tx_valid, 0);
        applyStimulus(0, 4'b1011, 1);
        checkOutput("drop_ptr_hold", src_ready, 4'b1000);

        // Pointer wrap: source 3 alone, then 0 and 3 together -> 0 first.
        applyStimulus(0, 4'b1000, 1);
        expectFrame(3, 8'h44);
        applyStimulus(0, 4'b1001, 1);
        expectFrame(0, 8'h11);
        expectFrame(3, 8'h44);
        applyStimulus(0, 4'b0000, 1);
        checkOutput("final_idle_ready", src_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
